hybrid_branch_predictor: RTL



---
 rtl/hybrid_branch_predictor_pkg.sv | 17 +
 rtl/hybrid_branch_predictor_sat_counter2.sv | 21 ++
 rtl/hybrid_branch_predictor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hybrid_branch_predictor_pkg.sv
// Shared definitions for the hybrid branch predictor: 2-bit counter encodings,
// reset values and BTB entry field widths.
package hybrid_branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CTR_RESET     = WNT;
    localparam logic [1:0] CHOOSER_RESET = WNT;

    localparam int BTB_VALID_BITS   = 1;
    localparam int BTB_TAG_BITS_DEF = 24;
    localparam int BTB_TARGET_BITS  = 32;

endpackage

// File: rtl/hybrid_branch_predictor_sat_counter2.sv
// Combinational next value of a 2-bit saturating counter.
module sat_counter2
    import hybrid_branch_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       inc,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != ST) begin
                nxt = cur + 2'd1;
            end
        end else if (cur != SNT) begin
            nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/hybrid_branch_predictor.sv
// Fetch-stage next-PC generator: bimodal + gshare direction tables picked by a
// per-PC chooser, with a direct-mapped BTB supplying taken targets.
module hybrid_branch_predictor
    import hybrid_branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6,
    parameter int TAG_BITS   = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_next_pc,
    output logic                pred_src,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [1:0]                 bim_reg        [DEPTH];
    logic [1:0]                 gs_reg         [DEPTH];
    logic [1:0]                 cho_reg        [DEPTH];
    logic                       btb_valid_reg  [DEPTH];
    logic [TAG_BITS-1:0]        btb_tag_reg    [DEPTH];
    logic [BTB_TARGET_BITS-1:0] btb_target_reg [DEPTH];
    logic [GHR_BITS-1:0]        ghr_reg;

    // Lookup path: purely combinational from registered state.
    logic [INDEX_BITS-1:0] bi_idx;
    logic [INDEX_BITS-1:0] gs_idx;
    logic [TAG_BITS-1:0]   pred_tag;
    logic                  btb_hit;
    logic                  dir;
    logic [31:0]           pc_plus4;

    assign bi_idx   = pred_pc[INDEX_BITS+1:2];
    assign gs_idx   = bi_idx ^ INDEX_BITS'(ghr_reg);
    assign pred_tag = pred_pc[31:INDEX_BITS+2];
    assign btb_hit  = btb_valid_reg[bi_idx] && (btb_tag_reg[bi_idx] == pred_tag);
    assign pc_plus4 = pred_pc + 32'd4;

    always_comb begin
        pred_src     = cho_reg[bi_idx][1];
        dir          = pred_src ? gs_reg[gs_idx][1] : bim_reg[bi_idx][1];
        pred_taken   = btb_hit && dir;
        pred_next_pc = pred_taken ? btb_target_reg[bi_idx] : pc_plus4;
        pred_ghr     = ghr_reg;
    end

    // Update path: one saturating-counter instance per trained table.
    logic [INDEX_BITS-1:0] u_idx;
    logic [INDEX_BITS-1:0] u_gs;
    logic [TAG_BITS-1:0]   u_tag;
    logic [1:0]            bim_next;
    logic [1:0]            gs_next;
    logic [1:0]            cho_next;
    logic                  bim_u_dir;
    logic                  gs_u_dir;
    logic                  cho_we;

    assign u_idx     = upd_pc[INDEX_BITS+1:2];
    assign u_gs      = u_idx ^ INDEX_BITS'(upd_ghr);
    assign u_tag     = upd_pc[31:INDEX_BITS+2];
    assign bim_u_dir = bim_reg[u_idx][1];
    assign gs_u_dir  = gs_reg[u_gs][1];
    // The chooser only learns when the components disagree.
    assign cho_we    = upd_valid && (bim_u_dir != gs_u_dir);

    sat_counter2 u_bim_ctr (
        .cur (bim_reg[u_idx]),
        .inc (upd_taken),
        .nxt (bim_next)
    );

    sat_counter2 u_gs_ctr (
        .cur (gs_reg[u_gs]),
        .inc (upd_taken),
        .nxt (gs_next)
    );

    sat_counter2 u_cho_ctr (
        .cur (cho_reg[u_idx]),
        .inc (gs_u_dir == upd_taken),
        .nxt (cho_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bim_reg[i]        <= CTR_RESET;
                gs_reg[i]         <= CTR_RESET;
                cho_reg[i]        <= CHOOSER_RESET;
                btb_valid_reg[i]  <= 1'b0;
                btb_tag_reg[i]    <= '0;
                btb_target_reg[i] <= '0;
            end
            ghr_reg <= '0;
        end else begin
            if (upd_valid) begin
                bim_reg[u_idx] <= bim_next;
                gs_reg[u_gs]   <= gs_next;
                if (cho_we) begin
                    cho_reg[u_idx] <= cho_next;
                end
                if (upd_taken) begin
                    btb_valid_reg[u_idx]  <= 1'b1;
                    btb_tag_reg[u_idx]    <= u_tag;
                    btb_target_reg[u_idx] <= upd_target;
                end
            end
            // History repair from execute overrides this cycle's speculative shift.
            if (upd_valid && upd_mispredict) begin
                ghr_reg <= {upd_ghr[GHR_BITS-2:0], upd_taken};
            end else if (pred_valid && btb_hit) begin
                ghr_reg <= {ghr_reg[GHR_BITS-2:0], pred_taken};
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

endmodule
